// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid buffer; latency 1 cycle.
// Backpressure: in_ready is a flop (no combinational path from out_ready); the skid absorbs one word on stall.
// Optional performance counters are enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bp_cnt
);

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;
    logic              rdy_q;
    logic              accept, drain;

    assign accept    = in_valid & rdy_q;
    assign drain     = main_v_q & out_ready;
    assign in_ready  = rdy_q;
    assign out_valid = main_v_q;
    assign out_data  = main_d_q;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;
        if (flush) begin
            // Data registers keep their contents; only the valid bits drop.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q) begin
            if (accept) begin
                main_v_d = 1'b1;
                main_d_d = in_data;
            end
        end else if (!skid_v_q) begin
            if (accept && drain) begin
                main_d_d = in_data;
            end else if (drain) begin
                main_v_d = 1'b0;
            end else if (accept) begin
                skid_v_d = 1'b1;
                skid_d_d = in_data;
            end
        end else if (drain) begin
            main_d_d = skid_d_q;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            main_d_q <= '0;
            skid_d_q <= '0;
            rdy_q    <= 1'b1;
        end else begin
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
            main_d_q <= main_d_d;
            skid_d_q <= skid_d_d;
            rdy_q    <= ~skid_v_d;
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, bp_cnt_q;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            bp_cnt_q    <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
            bp_cnt_q    <= '0;
        end else begin
            if (main_v_q && !out_ready && stall_cnt_q != CNT_MAX)
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (in_valid && !rdy_q && bp_cnt_q != CNT_MAX)
                bp_cnt_q <= bp_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign bp_cnt    = bp_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign stall_cnt      = '0;
    assign bp_cnt         = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized checks of pipe_skid_reg against a small queue model.
module tb_pipe_skid_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 2;

    logic              CLK = 1'b0;
    logic              RST;
    logic              flush, in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [DATA_W-1:0] in_data, out_data;
    logic [CNT_W-1:0]  stall_cnt, bp_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .cnt_clr   (cnt_clr),
        .stall_cnt (stall_cnt),
        .bp_cnt    (bp_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_ab();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA;
        step();
        in_data   = 32'hB;
        step();
        check("fill_full_rdy", {31'd0, in_ready}, 32'd0);
        check("fill_full_dat", out_data, 32'hA);
    endtask

    logic [DATA_W-1:0] mq[$];
    logic              m_acc, m_drn;

    initial begin
        RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cnt_clr = 1'b0; in_data = '0;
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        check("rst_stall_cnt", {30'd0, stall_cnt}, 32'd0);
        check("rst_bp_cnt",    {30'd0, bp_cnt}, 32'd0);
        RST = 1'b0;
        step();

        // Streaming at full throughput
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
            check("stream_valid", {31'd0, out_valid}, 32'd1);
            check("stream_data",  out_data, i);
            check("stream_rdy",   {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_empty", {31'd0, out_valid}, 32'd0);

        // Stall fills the skid, then release drains in order without gaps
        fill_ab();
        in_data = 32'hC;
        step();
        check("stall_hold_dat", out_data, 32'hA);
        check("stall_hold_rdy", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        check("rel_b_dat", out_data, 32'hB);
        check("rel_b_rdy", {31'd0, in_ready}, 32'd1);
        step();
        check("rel_c_dat", out_data, 32'hC);
        check("rel_c_vld", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("rel_empty", {31'd0, out_valid}, 32'd0);

        // Flush while FULL with a word offered
        fill_ab();
        in_data = 32'hD;
        flush   = 1'b1;
        step();
        flush = 1'b0;
        check("flush_vld", {31'd0, out_valid}, 32'd0);
        check("flush_rdy", {31'd0, in_ready}, 32'd1);
        in_data   = 32'hE;
        out_ready = 1'b1;
        step();
        check("post_flush_dat", out_data, 32'hE);
        check("post_flush_vld", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        check("post_flush_empty", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while FULL
        fill_ab();
        in_valid = 1'b0;
        #2 RST = 1'b1;
        #1;
        check("arst_vld", {31'd0, out_valid}, 32'd0);
        check("arst_dat", out_data, 32'd0);
        check("arst_rdy", {31'd0, in_ready}, 32'd1);
        check("arst_stall", {30'd0, stall_cnt}, 32'd0);
        check("arst_bp", {30'd0, bp_cnt}, 32'd0);
        #1 RST = 1'b0;
        step();

        // Stall counter saturation and clear
        cnt_clr = 1'b1;
        step();
        cnt_clr   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h55;
        step();
        in_valid = 1'b0;
        step();
`ifdef PIPE_SKID_PERF_EN
        check("stall_cnt_1", {30'd0, stall_cnt}, 32'd1);
`else
        check("stall_cnt_off", {30'd0, stall_cnt}, 32'd0);
`endif
        for (int i = 0; i < 5; i++) step();
`ifdef PIPE_SKID_PERF_EN
        check("stall_cnt_sat", {30'd0, stall_cnt}, 32'd3);
`else
        check("stall_cnt_off2", {30'd0, stall_cnt}, 32'd0);
`endif
        check("bp_cnt_zero", {30'd0, bp_cnt}, 32'd0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("stall_cnt_clr", {30'd0, stall_cnt}, 32'd0);
        out_ready = 1'b1;
        step();
        check("cnt_drain_empty", {31'd0, out_valid}, 32'd0);

        // Randomized traffic against a queue model
        mq.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            check("rnd_rdy", {31'd0, in_ready}, {31'd0, mq.size() < 2});
            check("rnd_vld", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) check("rnd_dat", out_data, mq[0]);
            if (!in_ready) check("rnd_legal", {31'd0, out_valid}, 32'd1);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            in_data   = $urandom;
            m_acc = in_valid && (mq.size() < 2);
            m_drn = out_ready && (mq.size() > 0);
            if (flush) begin
                mq.delete();
            end else begin
                if (m_drn) void'(mq.pop_front());
                if (m_acc) mq.push_back(in_data);
            end
            step();
        end
        flush = 1'b0;
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
